regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 114 +++++++++++
 tb/tb_regfile.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 32 x DATA_W register file with two read ports, optional write-to-read forwarding,
// and a pending-write scoreboard reporting per-port operand hazards.
module regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [4:0]        raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [4:0]        raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rd,
   input  logic              flush,
   output logic              busy1_o,
   output logic              busy2_o,
   output logic [5:0]        pending_cnt_o
);
   localparam int unsigned NREG = 32;
   localparam int unsigned CW   = 6;
   localparam bit          FWD  = (BYPASS != 0);

   logic [DATA_W-1:0] mem [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_nxt;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_nxt;
   logic              wr_en;
   logic              hit1;
   logic              hit2;

   assign wr_en = we && (waddr != '0);
   assign hit1  = FWD && we && (waddr == raddr1);
   assign hit2  = FWD && we && (waddr == raddr2);

   // storage; register 0 is never written
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[waddr] <= wdata;
      end
   end

   // scoreboard next state: flush beats issue, issue beats writeback
   always_comb begin
      busy_nxt = busy_q;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         if (wr_en) begin
            busy_nxt[waddr] = 1'b0;
         end
         if (issue_valid && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
         end
      end
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      cnt_nxt = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_nxt;
         cnt_q  <= cnt_nxt;
      end
   end

   assign pending_cnt_o = cnt_q;

   // read ports; forwarded data is by definition not busy, and reset forces zeros
   always_comb begin
      rdata1  = '0;
      busy1_o = 1'b0;
      if (rst && re1 && (raddr1 != '0)) begin
         if (hit1) begin
            rdata1 = wdata;
         end else begin
            rdata1  = mem[raddr1];
            busy1_o = busy_q[raddr1];
         end
      end
   end

   always_comb begin
      rdata2  = '0;
      busy2_o = 1'b0;
      if (rst && re2 && (raddr2 != '0)) begin
         if (hit2) begin
            rdata2 = wdata;
         end else begin
            rdata2  = mem[raddr2];
            busy2_o = busy_q[raddr2];
         end
      end
   end
endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile: stimulus pushes expected port values into a queue,
// a monitor process pops and compares them against the DUT.
module tb_regfile;
   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        flush;
   logic        busy1_o;
   logic        busy2_o;
   logic [5:0]  pending_cnt_o;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        b1;
      logic        b2;
      logic [5:0]  cnt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_vec  = 0;
   int    n_fail = 0;

   regfile #(.DATA_W(32), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
      .busy1_o(busy1_o), .busy2_o(busy2_o), .pending_cnt_o(pending_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // monitor: compares DUT outputs whenever an expectation is posted
   initial begin
      exp_t  e;
      exp_t  act;
      string nm;
      forever begin
         wait (exp_q.size() > 0);
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         act = '{d1: rdata1, d2: rdata2, b1: busy1_o, b2: busy2_o, cnt: pending_cnt_o};
         n_vec++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b cnt=%0d, want d1=%h d2=%h b1=%b b2=%b cnt=%0d",
                     nm, act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
         end
      end
   end

   task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                      input logic iv, input logic [4:0] ir, input logic fl);
      @(negedge clk);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
      issue_valid = iv; issue_rd = ir; flush = fl;
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] d1, input logic [31:0] d2,
                      input logic b1, input logic b2, input logic [5:0] cnt);
      exp_q.push_back('{d1: d1, d2: d2, b1: b1, b2: b2, cnt: cnt});
      name_q.push_back(nm);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: monitor did not consume expectation (queue=%0d, want 0)", nm, exp_q.size());
         exp_q.delete();
         name_q.delete();
      end
   endtask

   initial begin
      rst = 1'b0;
      cyc(1, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      // inputs active during reset must not leak to the outputs
      cyc(1, 5'd7, 32'hFFFF_FFFF, 1, 5'd7, 1, 5'd3, 1, 5'd3, 0);
      chk("reset_outputs", 32'h0, 32'h0, 0, 0, 6'd0);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      rst = 1'b1;
      #1;
      chk("after_release", 32'h0, 32'h0, 0, 0, 6'd0);

      cyc(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      chk("write_x5_reads_off", 32'h0, 32'h0, 0, 0, 6'd0);
      cyc(1, 5'd0, 32'h0000_1234, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0);
      chk("read_x5", 32'hDEAD_BEEF, 32'h0, 0, 0, 6'd0);
      cyc(0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd5, 0, 5'd0, 0);
      chk("read_x0_after_write", 32'h0, 32'hDEAD_BEEF, 0, 0, 6'd0);

      cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0);
      chk("issue_x7", 32'h0, 32'h0, 0, 0, 6'd0);
      cyc(1, 5'd7, 32'hA5A5_A5A5, 1, 5'd5, 1, 5'd7, 0, 5'd0, 0);
      chk("bypass_x7_busy_masked", 32'hDEAD_BEEF, 32'hA5A5_A5A5, 0, 0, 6'd1);

      cyc(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd7, 1, 5'd3, 0);
      chk("x7_stored_issue_x3", 32'h0, 32'hA5A5_A5A5, 0, 0, 6'd0);
      cyc(0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0);
      chk("x3_busy", 32'h0, 32'h0, 1, 0, 6'd1);
      cyc(1, 5'd3, 32'h0000_0033, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0);
      chk("wb_x3_bypass", 32'h0000_0033, 32'h0, 0, 0, 6'd1);
      cyc(0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0);
      chk("x3_cleared", 32'h0000_0033, 32'h0, 0, 0, 6'd0);

      cyc(1, 5'd4, 32'h0000_0044, 0, 5'd0, 1, 5'd4, 1, 5'd4, 0);
      chk("issue_wb_x4_same", 32'h0, 32'h0000_0044, 0, 0, 6'd0);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd4, 1, 5'd4, 0);
      chk("x4_still_busy_reissue", 32'h0, 32'h0000_0044, 0, 1, 6'd1);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd4, 0, 5'd0, 0);
      chk("reissue_count_held", 32'h0, 32'h0000_0044, 0, 1, 6'd1);

      cyc(1, 5'd5, 32'h0000_55AA, 1, 5'd4, 0, 5'd0, 0, 5'd0, 0);
      chk("wb_nonbusy_x5", 32'h0000_0044, 32'h0, 1, 0, 6'd1);
      cyc(0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd4, 0, 5'd0, 0);
      chk("x5_updated_count_same", 32'h0000_55AA, 32'h0000_0044, 0, 1, 6'd1);

      cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd1, 0);
      chk("issue_x1", 32'h0, 32'h0, 0, 0, 6'd1);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd2, 0);
      chk("issue_x2", 32'h0, 32'h0, 0, 0, 6'd2);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0);
      chk("issue_x3", 32'h0, 32'h0, 0, 0, 6'd3);
      cyc(1, 5'd9, 32'h0000_0055, 1, 5'd1, 1, 5'd2, 0, 5'd0, 1);
      chk("flush_cycle", 32'h0, 32'h0, 1, 1, 6'd4);
      cyc(0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd3, 0, 5'd0, 0);
      chk("after_flush", 32'h0000_0055, 32'h0000_0033, 0, 0, 6'd0);

      cyc(1, 5'd10, 32'h0000_0077, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      chk("load_x10", 32'h0, 32'h0, 0, 0, 6'd0);
      cyc(0, 5'd0, 32'h0, 1, 5'd10, 0, 5'd0, 1, 5'd10, 0);
      chk("issue_x10", 32'h0000_0077, 32'h0, 0, 0, 6'd0);
      cyc(0, 5'd0, 32'h0, 1, 5'd10, 0, 5'd0, 0, 5'd0, 0);
      chk("x10_busy", 32'h0000_0077, 32'h0, 1, 0, 6'd1);
      #1;
      we = 1'b1; waddr = 5'd10; wdata = 32'h0000_0099; re2 = 1'b1; raddr2 = 5'd10;
      rst = 1'b0;
      #1;
      chk("async_reset_midcycle", 32'h0, 32'h0, 0, 0, 6'd0);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      rst = 1'b1;
      #1;
      cyc(0, 5'd0, 32'h0, 1, 5'd10, 1, 5'd5, 0, 5'd0, 0);
      chk("x10_cleared_by_reset", 32'h0, 32'h0, 0, 0, 6'd0);

      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
